clock_step_ctrl: RTL and testbench

CLOCK_STEP_CTRL -- requirements
Module: clock_step_ctrl

---
 rtl/clock_step_ctrl.sv | 154 +++++++++++++++
 tb/tb_clock_step_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/clock_step_ctrl.sv
// CPU clock-step controller: synchronised, debounced buttons drive
// a reset stretcher and an auto/manual single-step clock enable.
module clock_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned AUTO_DIV        = 1,
    parameter int unsigned RESET_STRETCH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reset_btn,
    input  logic        manual_clk_sw,
    input  logic        pulse_clk_btn,
    output logic        cpu_clk_en,
    output logic        cpu_reset,
    output logic        manual_mode,
    output logic [15:0] step_count
);

    localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] DIV_LAST = 8'(AUTO_DIV - 1);
    localparam logic [7:0] STRETCH  = 8'(RESET_STRETCH);

    typedef enum logic [1:0] {
        RESET_HOLD,
        AUTO,
        MANUAL
    } state_t;

    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] db;
    logic [7:0] db_cnt [3];
    logic       pulse_q;

    state_t     state, state_n;
    logic [7:0] stretch, stretch_n;
    logic [7:0] div, div_n;
    logic       en_n;

    logic rst_db;
    logic sw_db;
    logic pulse_rise;

    // bit 0 = reset button, bit 1 = mode switch, bit 2 = step button
    assign raw        = {pulse_clk_btn, manual_clk_sw, reset_btn};
    assign rst_db     = db[0];
    assign sw_db      = db[1];
    assign pulse_rise = db[2] & ~pulse_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            pulse_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            pulse_q <= db[2];
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= ~db[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 8'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        state_n   = state;
        stretch_n = stretch;
        div_n     = div;
        en_n      = 1'b0;
        unique case (state)
            RESET_HOLD: begin
                if (rst_db) begin
                    stretch_n = STRETCH;
                end else if (stretch <= 8'd1) begin
                    stretch_n = '0;
                    div_n     = '0;
                    state_n   = sw_db ? MANUAL : AUTO;
                end else begin
                    stretch_n = stretch - 8'd1;
                end
            end
            AUTO: begin
                if (rst_db) begin
                    state_n   = RESET_HOLD;
                    stretch_n = STRETCH;
                    div_n     = '0;
                end else if (sw_db) begin
                    state_n = MANUAL;
                    div_n   = '0;
                end else begin
                    en_n  = (div == DIV_LAST);
                    div_n = (div == DIV_LAST) ? 8'd0 : div + 8'd1;
                end
            end
            MANUAL: begin
                if (rst_db) begin
                    state_n   = RESET_HOLD;
                    stretch_n = STRETCH;
                    div_n     = '0;
                end else if (!sw_db) begin
                    state_n = AUTO;
                    div_n   = '0;
                end else begin
                    en_n = pulse_rise;
                end
            end
            default: begin
                state_n   = RESET_HOLD;
                stretch_n = STRETCH;
                div_n     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RESET_HOLD;
            stretch     <= STRETCH;
            div         <= '0;
            cpu_clk_en  <= 1'b0;
            cpu_reset   <= 1'b1;
            manual_mode <= 1'b0;
            step_count  <= '0;
        end else begin
            state       <= state_n;
            stretch     <= stretch_n;
            div         <= div_n;
            cpu_clk_en  <= en_n;
            cpu_reset   <= (state_n == RESET_HOLD);
            manual_mode <= (state_n == MANUAL);
            // count includes the strobe being issued on this edge
            if (state_n == RESET_HOLD) begin
                step_count <= '0;
            end else begin
                step_count <= step_count + {15'd0, en_n};
            end
        end
    end

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Directed bench for clock_step_ctrl with DEBOUNCE_CYCLES=4,
// AUTO_DIV=2, RESET_STRETCH=8.
module tb_clock_step_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset_btn = 1'b0;
    logic        manual_clk_sw = 1'b0;
    logic        pulse_clk_btn = 1'b0;
    logic        cpu_clk_en;
    logic        cpu_reset;
    logic        manual_mode;
    logic [15:0] step_count;

    int checks = 0;
    int errors = 0;
    int pulses;

    clock_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_DIV       (2),
        .RESET_STRETCH  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .reset_btn    (reset_btn),
        .manual_clk_sw(manual_clk_sw),
        .pulse_clk_btn(pulse_clk_btn),
        .cpu_clk_en   (cpu_clk_en),
        .cpu_reset    (cpu_reset),
        .manual_mode  (manual_mode),
        .step_count   (step_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // power-on
        repeat (3) tick();
        check("rst_cpu_reset", 16'(cpu_reset), 16'd1);
        check("rst_clk_en", 16'(cpu_clk_en), 16'd0);
        check("rst_manual", 16'(manual_mode), 16'd0);
        check("rst_count", step_count, 16'd0);
        reset = 1'b0;
        repeat (7) tick();
        check("stretch_hold", 16'(cpu_reset), 16'd1);
        tick();
        check("stretch_release", 16'(cpu_reset), 16'd0);
        check("auto_mode", 16'(manual_mode), 16'd0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("auto_cadence", 16'(cpu_clk_en), 16'(k % 2 == 0));
        end
        check("auto_count5", step_count, 16'd5);

        // short reset_btn glitch
        for (int k = 11; k <= 22; k++) begin
            reset_btn = (k <= 12);
            tick();
            check("glitch_cadence", 16'(cpu_clk_en), 16'(k % 2 == 0));
            check("glitch_no_rst", 16'(cpu_reset), 16'd0);
        end
        check("glitch_count", step_count, 16'd11);

        // held reset_btn
        reset_btn = 1'b1;
        repeat (6) tick();
        check("btn_rst_early", 16'(cpu_reset), 16'd0);
        tick();
        check("btn_rst_on", 16'(cpu_reset), 16'd1);
        check("btn_rst_count", step_count, 16'd0);
        repeat (3) tick();
        reset_btn = 1'b0;
        repeat (13) tick();
        check("btn_rel_hold", 16'(cpu_reset), 16'd1);
        check("btn_rel_en", 16'(cpu_clk_en), 16'd0);
        tick();
        check("btn_rel_off", 16'(cpu_reset), 16'd0);

        // manual stepping
        manual_clk_sw = 1'b1;
        repeat (6) tick();
        check("sw_not_yet", 16'(manual_mode), 16'd0);
        tick();
        check("sw_manual", 16'(manual_mode), 16'd1);
        check("sw_no_strobe", 16'(cpu_clk_en), 16'd0);
        check("sw_count", step_count, 16'd3);
        for (int p = 1; p <= 3; p++) begin
            pulse_clk_btn = 1'b1;
            pulses = 0;
            repeat (6) begin
                tick();
                pulses += int'(cpu_clk_en);
            end
            check("step_early", 16'(pulses), 16'd0);
            pulse_clk_btn = 1'b0;
            tick();
            check("step_pulse", 16'(cpu_clk_en), 16'd1);
            check("step_count", step_count, 16'(3 + p));
            pulses = 0;
            repeat (12) begin
                tick();
                pulses += int'(cpu_clk_en);
            end
            check("step_single", 16'(pulses), 16'd0);
        end

        // bouncing step button
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            pulse_clk_btn = (i % 2 == 0);
            tick();
            pulses += int'(cpu_clk_en);
        end
        pulse_clk_btn = 1'b0;
        repeat (12) begin
            tick();
            pulses += int'(cpu_clk_en);
        end
        check("bounce_pulses", 16'(pulses), 16'd0);
        check("bounce_count", step_count, 16'd6);

        // back to auto
        manual_clk_sw = 1'b0;
        repeat (6) tick();
        check("back_still_man", 16'(manual_mode), 16'd1);
        tick();
        check("back_auto", 16'(manual_mode), 16'd0);
        check("back_no_strobe", 16'(cpu_clk_en), 16'd0);
        tick();
        check("back_div", 16'(cpu_clk_en), 16'd0);
        tick();
        check("back_first", 16'(cpu_clk_en), 16'd1);
        check("back_count", step_count, 16'd7);

        // counter wrap
        @(negedge clk);
        force dut.step_count = 16'hFFFE;
        @(negedge clk);
        release dut.step_count;
        check("wrap_loaded", step_count, 16'hFFFE);
        tick();
        check("wrap_ffff", step_count, 16'hFFFF);
        tick();
        check("wrap_hold", step_count, 16'hFFFF);
        tick();
        check("wrap_zero", step_count, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
